// File: rtl/bus_sequencer.sv
// bus_sequencer: expands valid/ready micro-commands into one-hot bus source selects and load enables.
// Define BUS_SEQ_MEMWAIT_EN to make FETCH hold in F1 until mem_ready is sampled high.
module bus_sequencer #(
  parameter int ALU_OP_W = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_kind,
  input  logic [3:0]          op_ra,
  input  logic [3:0]          op_rb,
  input  logic [3:0]          op_rc,
  input  logic [ALU_OP_W-1:0] op_alu,
  input  logic                mem_ready,
  output logic [23:0]         bus_src,
  output logic [15:0]         reg_in,
  output logic                hi_in,
  output logic                lo_in,
  output logic                y_in,
  output logic                z_in,
  output logic                pc_in,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                ir_in,
  output logic                inc_pc,
  output logic                mem_read,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                done
);
  typedef enum logic [3:0] {S_IDLE, S_F0, S_F1, S_F2, S_EXB, S_EXC, S_WLO, S_WHI, S_WB, S_MOV} state_t;
  localparam logic [1:0] K_MOVE = 2'd1, K_MULDIV = 2'd2, K_FETCH = 2'd3;
  state_t r_state, w_state_n;
  logic [1:0] r_kind, w_kind_n;
  logic [3:0] r_ra, r_rb, r_rc, w_ra_n, w_rb_n, w_rc_n;
  logic [ALU_OP_W-1:0] r_alu, w_alu_n, r_alu_op;
  logic [23:0] r_bus, w_bus_n;
  logic [15:0] r_reg, w_reg_n;
  logic r_ready, r_hi, r_lo, r_y, r_z, r_pc, r_mar, r_mdr, r_ir, r_inc, r_mrd, r_done;
  logic w_accept, w_f1_go;
`ifdef BUS_SEQ_MEMWAIT_EN
  assign w_f1_go = mem_ready;
`else
  logic w_unused;
  assign w_unused = mem_ready;
  assign w_f1_go = 1'b1;
`endif
  // Outputs are registered from the next state so they change only on clock edges.
  always_comb begin
    w_accept = op_valid & r_ready;
    w_kind_n = w_accept ? op_kind : r_kind;
    w_ra_n = w_accept ? op_ra : r_ra;
    w_rb_n = w_accept ? op_rb : r_rb;
    w_rc_n = w_accept ? op_rc : r_rc;
    w_alu_n = w_accept ? op_alu : r_alu;
    w_state_n = S_IDLE;
    case (r_state)
      S_IDLE: w_state_n = !w_accept ? S_IDLE : op_kind == K_MOVE ? S_MOV : op_kind == K_FETCH ? S_F0 : S_EXB;
      S_EXB: w_state_n = S_EXC;
      S_EXC: w_state_n = r_kind == K_MULDIV ? S_WLO : S_WB;
      S_WLO: w_state_n = S_WHI;
      S_F0: w_state_n = S_F1;
      S_F1: w_state_n = w_f1_go ? S_F2 : S_F1;
      default: w_state_n = S_IDLE;
    endcase
    w_bus_n = '0;
    case (w_state_n)
      S_MOV, S_EXB: w_bus_n[w_rb_n] = 1'b1;
      S_EXC: w_bus_n[w_rc_n] = 1'b1;
      S_WB, S_WLO, S_F1: w_bus_n[19] = 1'b1;
      S_WHI: w_bus_n[18] = 1'b1;
      S_F0: w_bus_n[20] = 1'b1;
      S_F2: w_bus_n[21] = 1'b1;
      default: w_bus_n = '0;
    endcase
    w_reg_n = '0;
    if (w_state_n == S_MOV || w_state_n == S_WB) w_reg_n[w_ra_n] = 1'b1;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_kind <= '0;
      r_ra <= '0;
      r_rb <= '0;
      r_rc <= '0;
      r_alu <= '0;
      r_ready <= 1'b0;
      r_bus <= '0;
      r_reg <= '0;
      r_hi <= 1'b0;
      r_lo <= 1'b0;
      r_y <= 1'b0;
      r_z <= 1'b0;
      r_pc <= 1'b0;
      r_mar <= 1'b0;
      r_mdr <= 1'b0;
      r_ir <= 1'b0;
      r_inc <= 1'b0;
      r_mrd <= 1'b0;
      r_alu_op <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_kind <= w_kind_n;
      r_ra <= w_ra_n;
      r_rb <= w_rb_n;
      r_rc <= w_rc_n;
      r_alu <= w_alu_n;
      r_ready <= w_state_n == S_IDLE;
      r_bus <= w_bus_n;
      r_reg <= w_reg_n;
      r_hi <= w_state_n == S_WHI;
      r_lo <= w_state_n == S_WLO;
      r_y <= w_state_n == S_EXB;
      r_z <= w_state_n == S_EXC || w_state_n == S_F0;
      r_pc <= w_state_n == S_F1;
      r_mar <= w_state_n == S_F0;
      r_mdr <= w_state_n == S_F1;
      r_ir <= w_state_n == S_F2;
      r_inc <= w_state_n == S_F0;
      r_mrd <= w_state_n == S_F1;
      r_alu_op <= w_state_n == S_EXC ? w_alu_n : '0;
      r_done <= w_state_n == S_MOV || w_state_n == S_WB || w_state_n == S_WHI || w_state_n == S_F2;
    end
  end
  assign op_ready = r_ready;
  assign bus_src = r_bus;
  assign reg_in = r_reg;
  assign hi_in = r_hi;
  assign lo_in = r_lo;
  assign y_in = r_y;
  assign z_in = r_z;
  assign pc_in = r_pc;
  assign mar_in = r_mar;
  assign mdr_in = r_mdr;
  assign ir_in = r_ir;
  assign inc_pc = r_inc;
  assign mem_read = r_mrd;
  assign alu_op = r_alu_op;
  assign done = r_done;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed plus random commands checked against a per-cycle expected-output model.
module tb_bus_sequencer;
  logic clock = 1'b0, clear, op_valid, op_ready, mem_ready;
  logic [1:0] op_kind;
  logic [3:0] op_ra, op_rb, op_rc;
  logic [4:0] op_alu, alu_op;
  logic [23:0] bus_src;
  logic [15:0] reg_in;
  logic hi_in, lo_in, y_in, z_in, pc_in, mar_in, mdr_in, ir_in, inc_pc, mem_read, done;
  int tests = 0, fails = 0;

  bus_sequencer #(.ALU_OP_W(5)) dut (
    .clock(clock), .clear(clear), .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .op_ra(op_ra), .op_rb(op_rb), .op_rc(op_rc), .op_alu(op_alu), .mem_ready(mem_ready),
    .bus_src(bus_src), .reg_in(reg_in), .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in), .z_in(z_in),
    .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in), .inc_pc(inc_pc),
    .mem_read(mem_read), .alu_op(alu_op), .done(done)
  );

  always #5 clock = ~clock;

  logic [56:0] obs;
  assign obs = {bus_src, reg_in, hi_in, lo_in, y_in, z_in, pc_in, mar_in, mdr_in, ir_in,
                inc_pc, mem_read, alu_op, done, op_ready};

  localparam logic [56:0] IDLE_V = 57'd1;
  localparam logic [7:0] F_HI = 8'h80, F_LO = 8'h40, F_Y = 8'h20, F_Z = 8'h10,
                         F_PC = 8'h08, F_MAR = 8'h04, F_MDR = 8'h02, F_IR = 8'h01;

  typedef struct {logic [56:0] v; logic mr;} step_t;
  step_t exp_q[$];

  function automatic logic [56:0] mk(int src, int dst, logic [7:0] fl, logic inc, logic mrd,
                                     logic [4:0] op, logic dn);
    logic [23:0] b;
    logic [15:0] r;
    b = '0;
    r = '0;
    if (src >= 0) b[src] = 1'b1;
    if (dst >= 0) r[dst] = 1'b1;
    return {b, r, fl, inc, mrd, op, dn, 1'b0};
  endfunction

  task automatic push(logic [56:0] v, logic mr);
    exp_q.push_back('{v, mr});
  endtask

  task automatic build(logic [1:0] k, int a, int b, int c, logic [4:0] op, int waits);
    int n;
    exp_q.delete();
    case (k)
      2'd1: push(mk(b, a, 8'h0, 0, 0, 5'd0, 1), 1'($urandom));
      2'd3: begin
        push(mk(20, -1, F_MAR | F_Z, 1, 0, 5'd0, 0), 1'($urandom));
`ifdef BUS_SEQ_MEMWAIT_EN
        n = waits + 1;
`else
        n = 1;
`endif
        for (int j = 0; j < n; j++) push(mk(19, -1, F_PC | F_MDR, 0, 1, 5'd0, 0), j == waits);
        push(mk(21, -1, F_IR, 0, 0, 5'd0, 1), 1'($urandom));
      end
      default: begin
        push(mk(b, -1, F_Y, 0, 0, 5'd0, 0), 1'($urandom));
        push(mk(c, -1, F_Z, 0, 0, op, 0), 1'($urandom));
        if (k == 2'd0) push(mk(19, a, 8'h0, 0, 0, 5'd0, 1), 1'($urandom));
        else begin
          push(mk(19, -1, F_LO, 0, 0, 5'd0, 0), 1'($urandom));
          push(mk(18, -1, F_HI, 0, 0, 5'd0, 1), 1'($urandom));
        end
      end
    endcase
  endtask

  task automatic chk(string tag, logic [56:0] e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    tests++;
    assert ($countones(bus_src) <= 1) else begin
      fails++;
      $error("FAIL %s onehot bus_src=%h expected popcount<=1", tag, bus_src);
    end
  endtask

  task automatic issue(logic [1:0] k, logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [4:0] op);
    op_valid = 1'b1;
    op_kind = k;
    op_ra = a;
    op_rb = b;
    op_rc = c;
    op_alu = op;
  endtask

  task automatic run_cmd(string tag, logic [1:0] k, logic [3:0] a, logic [3:0] b, logic [3:0] c,
                         logic [4:0] op, int waits);
    build(k, a, b, c, op, waits);
    @(negedge clock);
    chk({tag, "-idle"}, IDLE_V);
    issue(k, a, b, c, op);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      op_valid = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
      op_kind = 2'($urandom);
      op_ra = 4'($urandom);
      op_rb = 4'($urandom);
      op_rc = 4'($urandom);
      op_alu = 5'($urandom);
      chk($sformatf("%s[%0d]", tag, i), exp_q[i].v);
      mem_ready = exp_q[i].mr;
    end
  endtask

  initial begin
    clear = 1'b1;
    mem_ready = 1'b0;
    issue(2'd1, 4'd3, 4'd7, 4'd0, 5'd0);
    repeat (2) @(negedge clock);
    chk("reset", 57'd0);
    clear = 1'b0;
    op_valid = 1'b0;
    @(negedge clock);
    chk("post_reset_ready", IDLE_V);

    run_cmd("move_3_7", 2'd1, 4'd3, 4'd7, 4'd0, 5'd0, 0);
    run_cmd("alu3_2_2_5", 2'd0, 4'd2, 4'd2, 4'd5, 5'd3, 0);
    run_cmd("muldiv_1_4", 2'd2, 4'd9, 4'd1, 4'd4, 5'd7, 0);
    run_cmd("fetch_w2", 2'd3, 4'd0, 4'd0, 4'd0, 5'd0, 2);
    run_cmd("fetch_w0", 2'd3, 4'd0, 4'd0, 4'd0, 5'd0, 0);
    run_cmd("move_r0", 2'd1, 4'd0, 4'd15, 4'd0, 5'd0, 0);

    build(2'd0, 6, 1, 2, 5'd5, 0);
    @(negedge clock);
    chk("clr-idle", IDLE_V);
    issue(2'd0, 4'd6, 4'd1, 4'd2, 5'd5);
    @(negedge clock);
    op_valid = 1'b0;
    chk("clr_exb", exp_q[0].v);
    @(negedge clock);
    chk("clr_exc", exp_q[1].v);
    clear = 1'b1;
    #1;
    chk("clr_async", 57'd0);
    @(negedge clock);
    chk("clr_hold", 57'd0);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("clr_after[%0d]", i), IDLE_V);
    end
    run_cmd("post_clr_alu3", 2'd0, 4'd6, 4'd1, 4'd2, 5'd5, 0);

    for (int n = 0; n < 60; n++)
      run_cmd($sformatf("rnd%0d", n), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              5'($urandom), int'($urandom_range(0, 3)));

    @(negedge clock);
    chk("final_idle", IDLE_V);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Register-transfer sequencer for the mini CPU's shared 32-bit datapath bus. Accepts one micro-command at a time over a valid/ready handshake and expands it into a cycle-by-cycle sequence of one-hot bus-source selects and destination load enables. The source-select vector drives the bus multiplexer's `*out` inputs directly. The sequencer guarantees that at most one source drives the bus per cycle.

## Interface
Parameters:
- `ALU_OP_W`, 5: width of ALU opcode field.

Ports:
- `clock`  in  1  system clock, rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  command present.
- `op_ready`  out  1  sequencer idle; command accepted on `op_valid & op_ready`.
- `op_kind`  in  2  0 = ALU3, 1 = MOVE, 2 = MULDIV, 3 = FETCH.
- `op_ra`, `op_rb`, `op_rc`  in  4 each  register indices (destination, source B, source C).
- `op_alu`  in  ALU_OP_W  ALU operation code.
- `mem_ready`  in  1  memory read data valid.
- `bus_src`  out  24  one-hot source select: bits 0–15 R0–R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 Y.
- `reg_in`  out  16  register-file load enables.
- `hi_in`, `lo_in`, `y_in`, `z_in`, `pc_in`, `mar_in`, `mdr_in`, `ir_in`  out  1 each  load enables.
- `inc_pc`, `mem_read`  out  1 each  ALU PC-increment mode; memory read strobe.
- `alu_op`  out  ALU_OP_W  ALU operation code.
- `done`  out  1  final cycle of a command.

## Operation
- Command fields are latched on acceptance; `op_*` inputs are ignored while busy.
- States: IDLE, F0, F1, F2, EXB, EXC, WLO, WHI, WB, MOV.
- Outputs are a decode of the registered state and latched fields. Every output is 0 in IDLE and at reset; `op_ready` is 1 in IDLE only.
- IDLE: on accept, go to MOV (MOVE), EXB (ALU3/MULDIV) or F0 (FETCH).
- MOV: `bus_src[rb]`, `reg_in[ra]`, `done` -> IDLE.
- EXB: `bus_src[rb]`, `y_in` -> EXC.
- EXC: `bus_src[rc]`, `alu_op` = latched op, `z_in` -> WB (ALU3) or WLO (MULDIV).
- WB: `bus_src[19]`, `reg_in[ra]`, `done` -> IDLE.
- WLO: `bus_src[19]`, `lo_in` -> WHI.
- WHI: `bus_src[18]`, `hi_in`, `done` -> IDLE.
- F0: `bus_src[20]`, `mar_in`, `inc_pc`, `z_in` -> F1.
- F1: `bus_src[19]`, `pc_in`, `mem_read`, `mdr_in`. Advance to F2 when the memory-wait condition is satisfied (see Configuration).
- F2: `bus_src[21]`, `ir_in`, `done` -> IDLE.
- `alu_op` is 0 outside EXC.
- `bus_src` has at most one bit set in every cycle.
- Ra equal to Rb or Rc is legal: sources are read before the write-back state.
- R0 is an ordinary destination.

## Timing
- Accept at edge N; the first sequence state is active in cycle N+1.
- Latency from acceptance to `done`:
  - MOVE: 1 cycle.
  - ALU3: 3 cycles.
  - MULDIV: 4 cycles.
  - FETCH: 3 cycles plus memory-wait cycles.
- `op_ready` rises in the cycle after `done`. There is no back-to-back accept.
- `clear` asserted mid-command forces IDLE immediately (asynchronously). All enables drop; the partial command is abandoned with no `done`.
- During F1 stalls, every F1 output holds steady.

## Configuration
- `BUS_SEQ_MEMWAIT_EN` defined:
  - F1 holds until `mem_ready` = 1 is sampled, then goes to F2.
  - `mem_ready` = 1 in the first F1 cycle gives zero wait.
- Undefined:
  - F1 lasts exactly one cycle.
  - `mem_ready` is ignored.

## Test plan
- Reset: assert `clear` with `op_valid` = 1 -> all outputs 0, `op_ready` = 0. Release -> `op_ready` = 1 on the next cycle.
- MOVE ra=3, rb=7 -> in cycle N+1, `bus_src` = 0x000080, `reg_in` = 0x0008, `done` = 1. `op_ready` = 1 in N+2.
- ALU3 ra=2, rb=2, rc=5, op_alu=3 -> the following sequence, with `done` only in WB:
  - EXB: `bus_src` = 0x000004, `y_in`.
  - EXC: `bus_src` = 0x000020, `alu_op` = 3, `z_in`.
  - WB: `bus_src` = 0x080000, `reg_in` = 0x0004.
- MULDIV rb=1, rc=4 -> WLO (`bus_src` = 0x080000, `lo_in`), then WHI (`bus_src` = 0x040000, `hi_in`, `done`). `reg_in` = 0 throughout.
- FETCH with `BUS_SEQ_MEMWAIT_EN`, `mem_ready` low for 2 cycles -> F1 lasts 3 cycles with `mem_read` = 1 and `bus_src` = 0x080000, then F2 with `bus_src` = 0x200000, `ir_in`, `done`.
- `clear` pulsed during EXC of an ALU3 -> no `reg_in` or `done` ever asserts; the next command executes normally. Throughout every test, `bus_src` popcount ≤ 1.
